// File: rtl/btn_debounce_rep.sv
// N-channel push-button conditioner: two-flop synchroniser, tick-sampled debounce,
// press/release pulses and a per-channel auto-repeat pulse train for held keys.
module btn_debounce_rep #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 1250000,
  parameter int STABLE     = 2,
  parameter int REPEAT_DLY = 20,
  parameter int REPEAT_PER = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [N-1:0] BIN,
  input  logic [N-1:0] REP_EN,
  output logic [N-1:0] BLEVEL,
  output logic [N-1:0] BPRESS,
  output logic [N-1:0] BRELEASE,
  output logic [N-1:0] BREPEAT,
  output logic         TICK
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RPT = 2'd2} rstate_e;

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = $clog2(STABLE + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [N-1:0] RELEASED = {N{ACTIVE_LOW}};

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  logic          tick_q;
  logic [N-1:0]  sync1_q, sync2_q, sample;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, release_q, repeat_q;
  logic [N-1:0]  rise, fall, rep_fire;

  assign tick    = (tcnt_q == TW'(TICK_DIV - 1));
  assign tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
  assign sample  = sync2_q ^ RELEASED;
  assign level_d = level_q ^ (rise | fall);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      tcnt_q    <= tcnt_d;
      tick_q    <= tick;
      sync1_q   <= BIN;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= rise | rep_fire;
    end
  end

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_ch
    logic [SW-1:0] stab_q, stab_d;
    logic          toggle;
    rstate_e       state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Stability counter only counts consecutive samples that disagree with the level.
    always_comb begin
      stab_d = stab_q;
      toggle = 1'b0;
      if (tick) begin
        if (sample[gi] == level_q[gi]) begin
          stab_d = '0;
        end else if (stab_q == SW'(STABLE - 1)) begin
          stab_d = '0;
          toggle = 1'b1;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
    end

    assign rise[gi] = toggle & ~level_q[gi];
    assign fall[gi] = toggle &  level_q[gi];

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        stab_q  <= '0;
        state_q <= IDLE;
        rcnt_q  <= '0;
      end else begin
        stab_q  <= stab_d;
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (fall[gi]) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else if (rise[gi]) begin
        state_d = HOLD;
        rcnt_d  = '0;
      end else if (tick) begin
        case (state_q)
          HOLD: begin
            if (!REP_EN[gi]) begin
              rcnt_d = '0;
            end else if (rcnt_q == RW'(REPEAT_DLY - 1)) begin
              state_d = RPT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          RPT: begin
            if (!REP_EN[gi]) begin
              state_d = HOLD;
              rcnt_d  = '0;
            end else if (rcnt_q == RW'(REPEAT_PER - 1)) begin
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // A release on the same tick suppresses the repeat that would otherwise fire.
    always_comb begin
      rep_fire[gi] = 1'b0;
      if (tick && !fall[gi] && !rise[gi] && REP_EN[gi]) begin
        case (state_q)
          HOLD:    rep_fire[gi] = (rcnt_q == RW'(REPEAT_DLY - 1));
          RPT:     rep_fire[gi] = (rcnt_q == RW'(REPEAT_PER - 1));
          default: rep_fire[gi] = 1'b0;
        endcase
      end
    end
  end

  assign BLEVEL   = level_q;
  assign BPRESS   = press_q;
  assign BRELEASE = release_q;
  assign BREPEAT  = repeat_q;
  assign TICK     = tick_q;

endmodule

// File: tb/tb_btn_debounce_rep.sv
// Self-checking bench for btn_debounce_rep: a tick-level behavioural model compared every
// cycle, plus hand-computed checkpoints for reset, bounce, hold/repeat, gating and reset mid-hold.
`timescale 1ns/1ps
module tb_btn_debounce_rep;
  localparam int N          = 2;
  localparam int TICK_DIV   = 4;
  localparam int STABLE     = 2;
  localparam int REPEAT_DLY = 3;
  localparam int REPEAT_PER = 2;
  localparam bit ACTIVE_LOW = 1'b1;

  logic         clk    = 1'b0;
  logic         nrst   = 1'b0;
  logic [N-1:0] bin    = 2'b00;
  logic [N-1:0] rep_en = 2'b11;
  logic [N-1:0] blevel, bpress, brelease, brepeat;
  logic         tick;

  btn_debounce_rep #(
    .N(N), .TICK_DIV(TICK_DIV), .STABLE(STABLE),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .CLK(clk), .nRST(nrst), .BIN(bin), .REP_EN(rep_en),
    .BLEVEL(blevel), .BPRESS(bpress), .BRELEASE(brelease), .BREPEAT(brepeat), .TICK(tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: clock edges since reset, recent raw inputs, per-tick pressed samples.
  int           e;
  logic [N-1:0] hist[$];
  logic [N-1:0] tsamp[$];
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  logic         m_tick;
  int           anchor[N];
  int           cnt_press[N], cnt_rel[N], cnt_rep[N];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [N-1:0] raw;
    int           t, d;
    bit           all_diff;
    e = 0; m_level = '0; m_press = '0; m_release = '0; m_repeat = '0; m_tick = 1'b0;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        e = 0;
        hist.delete();
        tsamp.delete();
        m_level = '0; m_press = '0; m_release = '0; m_repeat = '0; m_tick = 1'b0;
        for (int ch = 0; ch < N; ch++) anchor[ch] = 0;
      end else begin
        e++;
        hist.push_back(bin);
        if (hist.size() > 3) void'(hist.pop_front());
        m_press = '0; m_release = '0; m_repeat = '0; m_tick = 1'b0;
        if (e % TICK_DIV == 0) begin
          t      = e / TICK_DIV;
          m_tick = 1'b1;
          // The sample seen on a tick is the raw input from two edges earlier.
          raw = (hist.size() >= 3) ? hist[hist.size() - 3] : {N{ACTIVE_LOW}};
          tsamp.push_back(raw ^ {N{ACTIVE_LOW}});
          if (tsamp.size() > STABLE) void'(tsamp.pop_front());
          for (int ch = 0; ch < N; ch++) begin
            all_diff = 1'b0;
            if (tsamp.size() >= STABLE) begin
              all_diff = 1'b1;
              for (int k = 0; k < STABLE; k++)
                if (tsamp[tsamp.size() - 1 - k][ch] == m_level[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
              m_level[ch] = ~m_level[ch];
              if (m_level[ch]) begin
                m_press[ch]  = 1'b1;
                m_repeat[ch] = 1'b1;
                anchor[ch]   = t;
              end else begin
                m_release[ch] = 1'b1;
              end
            end else if (m_level[ch]) begin
              if (!rep_en[ch]) begin
                anchor[ch] = t;
              end else begin
                d = t - anchor[ch];
                if (d >= REPEAT_DLY && ((d - REPEAT_DLY) % REPEAT_PER) == 0) m_repeat[ch] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("BLEVEL",   16'(blevel),   16'(m_level));
      check("BPRESS",   16'(bpress),   16'(m_press));
      check("BRELEASE", 16'(brelease), 16'(m_release));
      check("BREPEAT",  16'(brepeat),  16'(m_repeat));
      check("TICK",     16'(tick),     16'(m_tick));
      for (int ch = 0; ch < N; ch++) begin
        if (bpress[ch])   cnt_press[ch]++;
        if (brelease[ch]) cnt_rel[ch]++;
        if (brepeat[ch])  cnt_rep[ch]++;
      end
    end
  end

  task automatic next_tick();
    int guard;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((e % TICK_DIV) != 0 && guard < 2 * TICK_DIV);
    if ((e % TICK_DIV) != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_wait: got edge %0d expected a tick edge", e);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk); #1;
    for (int ch = 0; ch < N; ch++) begin
      cnt_press[ch] = 0; cnt_rel[ch] = 0; cnt_rep[ch] = 0;
    end
  endtask

  initial begin
    for (int ch = 0; ch < N; ch++) begin
      cnt_press[ch] = 0; cnt_rel[ch] = 0; cnt_rep[ch] = 0;
    end
    // Reset with both keys held down.
    repeat (3) @(negedge clk);
    check("rst_outputs", {7'b0, blevel, bpress, brelease, brepeat, tick}, 16'h0);
    nrst = 1'b1;
    next_tick();
    check("tick_first", 16'(tick), 16'd1);
    check("lvl_after_1tick", 16'(blevel), 16'd0);
    @(posedge clk); #1;
    check("tick_one_clk", 16'(tick), 16'd0);
    next_tick();
    check("rst_press", 16'(bpress), 16'h3);
    check("rst_level", 16'(blevel), 16'h3);
    check("rst_repeat", 16'(brepeat), 16'h3);

    // Release channel 0, channel 1 stays held and keeps repeating.
    bin[0] = 1'b1;
    next_tick();
    next_tick();
    check("rel0_pulse", 16'(brelease), 16'h1);
    check("rel0_level", 16'(blevel), 16'h2);
    check("rst_press_cnt0", 16'(cnt_press[0]), 16'd1);
    check("rst_press_cnt1", 16'(cnt_press[1]), 16'd1);

    // Bounce: single-sample lows never reach the level.
    bin[0] = 1'b0;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      bin[0] = 1'b0;
      next_tick();
      bin[0] = 1'b1;
      next_tick();
    end
    next_tick();
    check("bounce_press", 16'(cnt_press[0]), 16'd0);
    check("bounce_rel", 16'(cnt_rel[0]), 16'd0);
    check("bounce_rep", 16'(cnt_rep[0]), 16'd0);
    check("bounce_level", 16'(blevel[0]), 16'd0);

    // Press and hold channel 0 for 13 ticks so the release lands on a repeat slot.
    bin[0] = 1'b0;
    clear_counts();
    repeat (13) next_tick();
    bin[0] = 1'b1;
    next_tick();
    check("hold_level_still", 16'(blevel[0]), 16'd1);
    next_tick();
    check("hold_level_drop", 16'(blevel[0]), 16'd0);
    check("hold_rel_pulse", 16'(brelease[0]), 16'd1);
    check("hold_no_rep_rel", 16'(brepeat[0]), 16'd0);
    next_tick();
    check("hold_press_cnt", 16'(cnt_press[0]), 16'd1);
    check("hold_rel_cnt", 16'(cnt_rel[0]), 16'd1);
    check("hold_rep_cnt", 16'(cnt_rep[0]), 16'd6);

    // Repeat gating on channel 1.
    next_tick();
    rep_en = 2'b01;
    clear_counts();
    repeat (5) next_tick();
    check("gate_rep_now", 16'(brepeat[1]), 16'd0);
    check("gate_rep_cnt", 16'(cnt_rep[1]), 16'd0);
    rep_en = 2'b11;
    next_tick();
    check("reen_t1", 16'(brepeat[1]), 16'd0);
    next_tick();
    check("reen_t2", 16'(brepeat[1]), 16'd0);
    next_tick();
    check("reen_t3", 16'(brepeat[1]), 16'd1);

    // Press channel 0 and release channel 1 on the same sample.
    bin = 2'b10;
    next_tick();
    next_tick();
    check("simul_press", 16'(bpress), 16'h1);
    check("simul_rel", 16'(brelease), 16'h2);
    check("simul_level", 16'(blevel), 16'h1);

    // Reset in the middle of a held repeat.
    repeat (4) next_tick();
    #3;
    nrst = 1'b0;
    #1;
    check("midrst_outputs", {7'b0, blevel, bpress, brelease, brepeat, tick}, 16'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    clear_counts();
    next_tick();
    check("midrst_lvl_1tick", 16'(blevel), 16'h0);
    next_tick();
    check("midrst_press", 16'(bpress), 16'h1);
    check("midrst_level", 16'(blevel), 16'h1);
    check("midrst_repeat", 16'(brepeat), 16'h1);
    repeat (3) next_tick();
    check("midrst_no_rel0", 16'(cnt_rel[0]), 16'd0);
    check("midrst_no_rel1", 16'(cnt_rel[1]), 16'd0);
    check("midrst_press_cnt", 16'(cnt_press[0]), 16'd1);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
